fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the pipelined RV32 core: owns the PC, drives the instruction-memory
//  request/ready handshake, and registers {instr, pc, pc+4, valid} into the IF/ID pipeline register.
//  instr_d_o feeds the decode-stage control decoder; pc_src_i/pc_target_i come back from branch resolution.
//  Stall/flush come from the hazard unit; a one-entry hold buffer keeps a fetched word while stalled.
// PARAMETERS
//  A_WIDTH       32            address/data width
//  RESET_VECTOR  32'h0000_0000 PC after reset
//  NOP_INSTR     32'h0000_0013 bubble encoding (addi x0,x0,0)
// PORTS
//  clk           in   1        clock, rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  stall_i       in   1        hazard unit: hold PC and IF/ID
//  flush_i       in   1        hazard unit: bubble IF/ID, drop in-flight fetch
//  pc_src_i      in   1        redirect (taken branch/jump)
//  pc_target_i   in   A_WIDTH  redirect target
//  imem_req_o    out  1        fetch request valid
//  imem_addr_o   out  A_WIDTH  fetch address (= PC)
//  imem_rdata_i  in   A_WIDTH  fetched word, valid when imem_ready_i
//  imem_ready_i  in   1        word accepted/returned this cycle
//  instr_d_o     out  A_WIDTH  IF/ID instruction (to control decoder)
//  pc_d_o        out  A_WIDTH  IF/ID PC
//  pc_plus4_d_o  out  A_WIDTH  IF/ID PC+4
//  valid_d_o     out  1        IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (async, rst_n=0): PC=RESET_VECTOR, state=FETCH, hold buffer empty, instr_d_o=NOP_INSTR,
//   pc_d_o=0, pc_plus4_d_o=0, valid_d_o=0. imem_req_o=1 from the first cycle after rst_n rises.
//  imem_req_o = (state==FETCH); imem_addr_o = PC. Memory samples address only when ready=1;
//   address may change while ready=0 (no outstanding transactions).
//  States: FETCH (requesting), HOLD (word in buffer, downstream stalled).
//  Priority per cycle: pc_src_i > flush_i > stall_i > normal.
//  pc_src_i=1 (any state): PC<=pc_target_i & ~3; IF/ID<=bubble (NOP_INSTR, valid 0, pc fields 0);
//   buffer cleared; returning word discarded; state<=FETCH.
//  flush_i=1 (no redirect): IF/ID<=bubble; returning word discarded; buffer cleared; PC unchanged
//   (word refetched); state<=FETCH.
//  FETCH, ready=1, stall=0: IF/ID<={rdata, PC, PC+4, 1}; PC<=PC+4. Latency 1: word visible next cycle.
//  FETCH, ready=1, stall=1: IF/ID holds; buffer<={rdata, PC}; PC unchanged; state<=HOLD.
//  FETCH, ready=0, stall=0: IF/ID<=bubble; PC unchanged.
//  FETCH, ready=0, stall=1: IF/ID holds; PC unchanged.
//  HOLD, stall=1: everything holds; imem_req_o=0.
//  HOLD, stall=0: IF/ID<={buffer, 1}; PC<=buffered PC+4; state<=FETCH.
//  Arithmetic: PC+4 modulo 2^A_WIDTH (0xFFFF_FFFC -> 0x0000_0000); PC[1:0] always 00.
//  Reset mid-HOLD or mid-stall: all state returns to reset values at once; buffered word is lost.
// STRUCTURE
//  Package core_pkg: fetch_state_t enum {FETCH, HOLD}; NOP_INSTR localparam; if_id_t struct
//   {instr, pc, pc_plus4, valid}.
//  Sub-module if_id_reg: IF/ID register with load/hold/bubble controls and async active-low reset;
//   reused for the next pipeline boundary. FSM, PC and hold buffer stay in fetch_stage.
// TESTING
//  Reset then ready=1 always -> imem_addr 0,4,8...; instr_d_o = rdata one cycle later; valid_d_o=1.
//  ready low 3 cycles at PC=0x10 -> 3 bubbles (valid 0, instr 0x13), then word@0x10; PC stays 0x10.
//  stall=1 in the cycle ready=1 at PC=0x20 -> HOLD, req=0, IF/ID frozen; release -> word@0x20, PC=0x24.
//  pc_src=1, target=0x103 during HOLD -> bubble, buffer dropped, next imem_addr=0x100.
//  pc_src=1 and stall=1 same cycle -> redirect wins; flush alone at PC=0x40 -> bubble, refetch 0x40.
//  PC=0xFFFF_FFFC fetched -> pc_plus4_d_o=0, next addr 0; rst_n low mid-HOLD -> all reset values.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the RV32 pipeline front end: fetch FSM states and the IF/ID payload.
package core_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  function automatic if_id_t if_id_bubble(input logic [XLEN-1:0] nop);
    if_id_t b;
    b.instr    = nop;
    b.pc       = {XLEN{1'b0}};
    b.pc_plus4 = {XLEN{1'b0}};
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline boundary register with bubble/load/hold control; bubble overrides load.
module if_id_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;

  // pipeline register: reset/bubble to NOP, otherwise load or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= if_id_bubble(NOP);
    end else if (bubble_i) begin
      q_q <= if_id_bubble(NOP);
    end else if (load_i) begin
      q_q <= d_i;
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: PC, imem handshake, stall hold buffer and the IF/ID register.
module fetch_stage
  import core_pkg::*;
#(
  parameter int                 A_WIDTH      = XLEN,
  parameter logic [A_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [A_WIDTH-1:0] NOP_INSTR    = core_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               pc_src_i,
  input  logic [A_WIDTH-1:0] pc_target_i,
  output logic               imem_req_o,
  output logic [A_WIDTH-1:0] imem_addr_o,
  input  logic [A_WIDTH-1:0] imem_rdata_i,
  input  logic               imem_ready_i,
  output logic [A_WIDTH-1:0] instr_d_o,
  output logic [A_WIDTH-1:0] pc_d_o,
  output logic [A_WIDTH-1:0] pc_plus4_d_o,
  output logic               valid_d_o
);

  localparam logic [A_WIDTH-1:0] PC_STEP = A_WIDTH'(4);

  fetch_state_t       state_q, state_d;
  logic [A_WIDTH-1:0] pc_q, pc_d;
  logic [A_WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic [A_WIDTH-1:0] buf_pc_q, buf_pc_d;

  logic   ifid_load_s;
  logic   ifid_bubble_s;
  if_id_t ifid_in_s;
  if_id_t ifid_q_s;

  // next-state: redirect > flush > stall > normal fetch
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;
    ifid_load_s   = 1'b0;
    ifid_bubble_s = 1'b0;
    ifid_in_s     = '{instr: imem_rdata_i, pc: pc_q, pc_plus4: pc_q + PC_STEP, valid: 1'b1};

    if (pc_src_i) begin
      pc_d          = {pc_target_i[A_WIDTH-1:2], 2'b00};
      ifid_bubble_s = 1'b1;
      buf_instr_d   = {A_WIDTH{1'b0}};
      buf_pc_d      = {A_WIDTH{1'b0}};
      state_d       = FETCH;
    end else if (flush_i) begin
      ifid_bubble_s = 1'b1;
      buf_instr_d   = {A_WIDTH{1'b0}};
      buf_pc_d      = {A_WIDTH{1'b0}};
      state_d       = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready_i) begin
            if (stall_i) begin
              buf_instr_d = imem_rdata_i;
              buf_pc_d    = pc_q;
              state_d     = HOLD;
            end else begin
              ifid_load_s = 1'b1;
              pc_d        = pc_q + PC_STEP;
            end
          end else begin
            if (stall_i) begin
              ifid_load_s = 1'b0;
            end else begin
              ifid_bubble_s = 1'b1;
            end
          end
        end
        HOLD: begin
          if (stall_i) begin
            state_d = HOLD;
          end else begin
            ifid_in_s   = '{instr: buf_instr_q, pc: buf_pc_q,
                            pc_plus4: buf_pc_q + PC_STEP, valid: 1'b1};
            ifid_load_s = 1'b1;
            pc_d        = buf_pc_q + PC_STEP;
            state_d     = FETCH;
          end
        end
        default: begin
          ifid_bubble_s = 1'b1;
          state_d       = FETCH;
        end
      endcase
    end
  end

  // FSM, PC and hold buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_VECTOR;
      buf_instr_q <= {A_WIDTH{1'b0}};
      buf_pc_q    <= {A_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  if_id_reg #(
    .NOP (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ifid_load_s),
    .bubble_i (ifid_bubble_s),
    .d_i      (ifid_in_s),
    .q_o      (ifid_q_s)
  );

  assign imem_req_o   = (state_q == FETCH);
  assign imem_addr_o  = pc_q;
  assign instr_d_o    = ifid_q_s.instr;
  assign pc_d_o       = ifid_q_s.pc;
  assign pc_plus4_d_o = ifid_q_s.pc_plus4;
  assign valid_d_o    = ifid_q_s.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle comparison against a behavioural fetch model
// plus hand-computed literal expectations at the interesting points.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, pc_src, ready;
  logic [31:0] target;
  logic        req, valid;
  logic [31:0] addr, rdata, instr, pcd, pc4;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_buf_w, m_buf_pc;
  logic [31:0] e_instr, e_pc, e_pc4;
  logic        m_hold, e_valid;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0003;
  endfunction

  assign rdata = mem_word(addr);

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall),
    .flush_i      (flush),
    .pc_src_i     (pc_src),
    .pc_target_i  (target),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_rdata_i (rdata),
    .imem_ready_i (ready),
    .instr_d_o    (instr),
    .pc_d_o       (pcd),
    .pc_plus4_d_o (pc4),
    .valid_d_o    (valid)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_bubble();
    e_instr = 32'h0000_0013;
    e_pc    = 32'h0;
    e_pc4   = 32'h0;
    e_valid = 1'b0;
  endtask

  task automatic m_reset();
    m_pc     = 32'h0;
    m_hold   = 1'b0;
    m_buf_w  = 32'h0;
    m_buf_pc = 32'h0;
    m_bubble();
  endtask

  task automatic m_deliver(input logic [31:0] w, input logic [31:0] p);
    e_instr = w;
    e_pc    = p;
    e_pc4   = p + 32'd4;
    e_valid = 1'b1;
    m_pc    = p + 32'd4;
  endtask

  // one clock of the fetch rules, evaluated with the inputs present at the edge
  task automatic m_step();
    if (pc_src) begin
      m_pc   = target & ~32'd3;
      m_hold = 1'b0;
      m_bubble();
    end else if (flush) begin
      m_hold = 1'b0;
      m_bubble();
    end else if (m_hold) begin
      if (!stall) begin
        m_deliver(m_buf_w, m_buf_pc);
        m_hold = 1'b0;
      end
    end else if (ready) begin
      if (stall) begin
        m_buf_w  = mem_word(m_pc);
        m_buf_pc = m_pc;
        m_hold   = 1'b1;
      end else begin
        m_deliver(mem_word(m_pc), m_pc);
      end
    end else if (!stall) begin
      m_bubble();
    end
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    cmp("req",   {31'd0, req},   {31'd0, !m_hold});
    cmp("addr",  addr,           m_pc);
    cmp("instr", instr,          e_instr);
    cmp("pc_d",  pcd,            e_pc);
    cmp("pc4_d", pc4,            e_pc4);
    cmp("valid", {31'd0, valid}, {31'd0, e_valid});
  end

  task automatic cyc(input logic st, input logic fl, input logic ps,
                     input logic [31:0] tg, input logic rd);
    stall  = st;
    flush  = fl;
    pc_src = ps;
    target = tg;
    ready  = rd;
    @(posedge clk);
    if (!rst_n) m_reset();
    else        m_step();
    @(negedge clk);
    #1;
  endtask

  logic [1:0] mix [8] = '{2'b01, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b01, 2'b01};

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 1'b0; ready = 1'b0; target = 32'h0;
    m_reset();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cmp("rst_instr", instr, 32'h0000_0013);
    cmp("rst_valid", {31'd0, valid}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cmp("seq_pc_d",  pcd,   32'h0000_0008);
    cmp("seq_instr", instr, 32'hDEAD_000B);
    cmp("seq_addr",  addr,  32'h0000_000C);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cmp("nrdy_instr", instr, 32'h0000_0013);
    cmp("nrdy_addr",  addr,  32'h0000_0010);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cmp("rdy_pc_d",  pcd,   32'h0000_0010);
    cmp("rdy_instr", instr, 32'hDEAD_0013);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cmp("hold_req",  {31'd0, req}, 32'd0);
    cmp("hold_pc_d", pcd,          32'h0000_001C);
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cmp("rel_pc_d", pcd,  32'h0000_0020);
    cmp("rel_addr", addr, 32'h0000_0024);

    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
    cmp("redir_addr",  addr,           32'h0000_0100);
    cmp("redir_valid", {31'd0, valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cmp("redir_pc_d", pcd, 32'h0000_0100);

    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b1);
    cmp("ps_stall_addr", addr,         32'h0000_0040);
    cmp("ps_stall_req",  {31'd0, req}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    cmp("flush_addr",  addr,  32'h0000_0040);
    cmp("flush_instr", instr, 32'h0000_0013);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cmp("refetch_pc4", pc4, 32'h0000_0044);

    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cmp("wrap_pc_d", pcd,  32'hFFFF_FFFC);
    cmp("wrap_pc4",  pc4,  32'h0000_0000);
    cmp("wrap_addr", addr, 32'h0000_0000);

    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    #2 rst_n = 1'b0;
    #1 m_reset();
    cmp("arst_req",   {31'd0, req},   32'd1);
    cmp("arst_valid", {31'd0, valid}, 32'd0);
    cmp("arst_pc4",   pc4,            32'h0);
    cmp("arst_instr", instr,          32'h0000_0013);
    @(negedge clk); #1;
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cmp("post_rst_pc_d", pcd,  32'h0);
    cmp("post_rst_addr", addr, 32'h0000_0004);

    for (int i = 0; i < 8; i++) cyc(mix[i][1], 1'b0, 1'b0, 32'h0, mix[i][0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
